conv_seq_fsm: RTL and testbench
===============================

CONV_SEQ_FSM -- requirements
Module: conv_seq_fsm

Parameters
REQ-001 NB_ADDRESS, default 10, memory address width.
REQ-002 LATENCY, default 5, read-to-write pipeline latency of MCU+Conv in cycles; legal range 0 to 2**NB_ADDRESS-1.
REQ-003 NB_BLK, default 4, width of block counter.

Interface
REQ-004 CLK100MHZ  in  1  system clock; all logic on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 i_start  in  1  level from GPIO; its rising edge starts a frame.
REQ-007 i_next  in  1  level from GPIO; its rising edge advances the readback address.
REQ-008 i_last_addr  in  NB_ADDRESS  last address of a block (rows-1); latched on start.
REQ-009 i_nblk  in  NB_BLK  number of column blocks minus 1; latched on start.
REQ-010 o_RAddr  out  NB_ADDRESS  read address to MCU.
REQ-011 o_WAddr  out  NB_ADDRESS  write address to MCU.
REQ-012 o_sop / o_eop / o_chblk  out  1 each  start-of-processing level, end-of-processing level, change-block pulse.
REQ-013 o_valid  out  1  data valid to convolvers.
REQ-014 o_blk_idx  out  NB_BLK  current block index.
REQ-015 o_busy  out  1  high in RUN and CHBLK.

Function
REQ-016 All outputs are registered; no combinational input-to-output path.
REQ-017 States: IDLE, RUN, CHBLK; o_eop=1 only in IDLE; o_sop=o_valid=1 only in RUN; o_chblk=1 only in CHBLK.
REQ-018 Edge detection: one-cycle rising-edge detector per input (current=1, previous sample=0).
REQ-019 IDLE + start edge at cycle t: at t+1 state RUN, o_RAddr=0, o_WAddr=0, o_blk_idx=0, i_last_addr/i_nblk latched.
REQ-020 RUN, run counter c from 0 at first RUN cycle: o_RAddr=min(c, last), o_WAddr=max(0, c-LATENCY).
REQ-021 RUN ends on cycle where o_WAddr==last; RUN lasts last+LATENCY+1 cycles; last=0 legal.
REQ-022 End of RUN with o_blk_idx<nblk: next cycle CHBLK (valid=0, addresses 0), following cycle RUN with o_blk_idx+1, c=0.
REQ-023 End of RUN with o_blk_idx==nblk: next cycle IDLE, o_eop=1, addresses 0, o_blk_idx held.
REQ-024 Start edges in RUN/CHBLK ignored; i_next ignored outside IDLE.
REQ-025 IDLE + i_next edge: o_RAddr increments; wraps from latched last to 0; o_WAddr held 0.
REQ-026 Simultaneous start and next edges in IDLE: start wins, next dropped.
REQ-027 Changes of i_last_addr/i_nblk after start take effect only at next start.

Reset
REQ-028 rst (any state, incl. mid-RUN) forces next cycle: IDLE, o_eop=1, o_sop=0, o_chblk=0, o_valid=0, o_busy=0, o_RAddr=0, o_WAddr=0, o_blk_idx=0, latched last=0, nblk=0.
REQ-029 Edge-detector previous-sample registers reset to 1, so an input held high across reset release produces no edge.
REQ-030 rst has priority over every edge and state transition in the same cycle.

Structure
REQ-031 Shared package conv_pkg holds state encodings and default NB_ADDRESS/LATENCY/NB_BLK constants.
REQ-032 One sub-module, edge_det (1-bit rising-edge detector, sync reset to 1), instantiated for i_start and i_next.

Verification (LATENCY=5, NB_ADDRESS=10)
REQ-033 last=7, nblk=0, start pulse -> 13 RUN cycles, o_RAddr 0..7 then 7 held, o_WAddr 0 x6 then 1..7, o_eop=1 on 14th cycle.
REQ-034 last=7, nblk=1 -> RUN 13, one CHBLK cycle (o_chblk=1, o_valid=0), RUN 13 with o_blk_idx=1, then IDLE; exactly one o_chblk pulse.
REQ-035 IDLE, last=2, four i_next pulses -> o_RAddr 1,2,0,1.
REQ-036 rst asserted at c=4 of RUN -> next cycle all outputs at REQ-028 values; i_start held high through reset release -> stays IDLE until low then high.
REQ-037 Second start pulse at c=3 -> ignored, timing identical to REQ-033; simultaneous start+next in IDLE -> RUN, o_RAddr=0.
REQ-038 last=0, nblk=0 -> RUN 6 cycles, o_RAddr=0 throughout, o_WAddr=0, then IDLE.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and default sizing for the convolution sequencer.
// State encodings plus a helper that maps a state to its output flags.
package conv_pkg;

    localparam int DEF_NB_ADDRESS = 10;
    localparam int DEF_LATENCY    = 5;
    localparam int DEF_NB_BLK     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHBLK = 2'd2
    } state_t;

    typedef struct packed {
        logic sop;
        logic eop;
        logic chblk;
        logic valid;
        logic busy;
    } flags_t;

    function automatic flags_t state_flags(input state_t st);
        flags_t f;
        f = '0;
        unique case (st)
            ST_IDLE:  f.eop = 1'b1;
            ST_RUN: begin
                f.sop   = 1'b1;
                f.valid = 1'b1;
                f.busy  = 1'b1;
            end
            ST_CHBLK: begin
                f.chblk = 1'b1;
                f.busy  = 1'b1;
            end
            default:  f.eop = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/edge_det.sv
// Single-bit rising-edge detector for slow GPIO levels.
// The previous-sample register resets high so a level held across reset is not an edge.
module edge_det (
    input  logic CLK100MHZ,
    input  logic rst,
    input  logic i_din,
    output logic o_rise
);

    logic prev;

    always_ff @(posedge CLK100MHZ) begin
        if (rst) prev <= 1'b1;
        else     prev <= i_din;
    end

    assign o_rise = i_din & ~prev;

endmodule

// File: rtl/conv_seq_fsm.sv
// Frame sequencer for the MCU+Conv pipeline: walks read/write addresses per column
// block, inserts a change-block cycle between blocks, and allows readback stepping in IDLE.
module conv_seq_fsm
    import conv_pkg::*;
#(
    parameter int NB_ADDRESS = DEF_NB_ADDRESS,
    parameter int LATENCY    = DEF_LATENCY,
    parameter int NB_BLK     = DEF_NB_BLK
) (
    input  logic                  CLK100MHZ,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_next,
    input  logic [NB_ADDRESS-1:0] i_last_addr,
    input  logic [NB_BLK-1:0]     i_nblk,
    output logic [NB_ADDRESS-1:0] o_RAddr,
    output logic [NB_ADDRESS-1:0] o_WAddr,
    output logic                  o_sop,
    output logic                  o_eop,
    output logic                  o_chblk,
    output logic                  o_valid,
    output logic [NB_BLK-1:0]     o_blk_idx,
    output logic                  o_busy
);

    // Run counter needs one extra bit: it reaches last + LATENCY.
    localparam int              CW    = NB_ADDRESS + 1;
    localparam logic [CW-1:0]   LAT_C = CW'(LATENCY);

    logic start_rise;
    logic next_rise;

    state_t                state_q, state_d;
    flags_t                flags_q;
    logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
    logic [NB_ADDRESS-1:0] raddr_d, waddr_d;
    logic [NB_BLK-1:0]     blk_d;
    logic [NB_ADDRESS-1:0] last_q, last_d;
    logic [NB_BLK-1:0]     nblk_q, nblk_d;
    logic                  run_end;

    edge_det u_start_edge (
        .CLK100MHZ (CLK100MHZ),
        .rst       (rst),
        .i_din     (i_start),
        .o_rise    (start_rise)
    );

    edge_det u_next_edge (
        .CLK100MHZ (CLK100MHZ),
        .rst       (rst),
        .i_din     (i_next),
        .o_rise    (next_rise)
    );

    assign cnt_inc = cnt_q + 1'b1;
    // The block finishes on the cycle whose write address equals the latched last address.
    assign run_end = (cnt_q == ({1'b0, last_q} + LAT_C));

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        raddr_d = o_RAddr;
        waddr_d = o_WAddr;
        blk_d   = o_blk_idx;
        last_d  = last_q;
        nblk_d  = nblk_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    raddr_d = '0;
                    waddr_d = '0;
                    blk_d   = '0;
                    last_d  = i_last_addr;
                    nblk_d  = i_nblk;
                end else if (next_rise) begin
                    waddr_d = '0;
                    raddr_d = (o_RAddr >= last_q) ? '0 : o_RAddr + 1'b1;
                end
            end

            ST_RUN: begin
                if (run_end) begin
                    cnt_d   = '0;
                    raddr_d = '0;
                    waddr_d = '0;
                    state_d = (o_blk_idx == nblk_q) ? ST_IDLE : ST_CHBLK;
                end else begin
                    cnt_d   = cnt_inc;
                    raddr_d = (cnt_inc > {1'b0, last_q}) ? last_q
                                                         : cnt_inc[NB_ADDRESS-1:0];
                    waddr_d = (cnt_inc >= LAT_C) ? NB_ADDRESS'(cnt_inc - LAT_C) : '0;
                end
            end

            ST_CHBLK: begin
                state_d = ST_RUN;
                cnt_d   = '0;
                raddr_d = '0;
                waddr_d = '0;
                blk_d   = o_blk_idx + 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                raddr_d = '0;
                waddr_d = '0;
            end
        endcase
    end

    // Flags are registered from the next state so every output comes straight from a flop.
    always_ff @(posedge CLK100MHZ) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            state_q   <= ST_IDLE;
            flags_q   <= state_flags(ST_IDLE);
            cnt_q     <= '0;
            o_RAddr   <= '0;
            o_WAddr   <= '0;
            o_blk_idx <= '0;
            last_q    <= '0;
            nblk_q    <= '0;
        end else begin
            state_q   <= state_d;
            flags_q   <= state_flags(state_d);
            cnt_q     <= cnt_d;
            o_RAddr   <= raddr_d;
            o_WAddr   <= waddr_d;
            o_blk_idx <= blk_d;
            last_q    <= last_d;
            nblk_q    <= nblk_d;
        end
    end

    assign o_sop   = flags_q.sop;
    assign o_eop   = flags_q.eop;
    assign o_chblk = flags_q.chblk;
    assign o_valid = flags_q.valid;
    assign o_busy  = flags_q.busy;

endmodule

// File: tb/tb_conv_seq_fsm.sv
// Self-checking bench for conv_seq_fsm: expected output vectors are queued as stimulus
// is applied and compared one cycle later, after the DUT's register update.
module tb_conv_seq_fsm;

    localparam int NB_ADDRESS = 10;
    localparam int LATENCY    = 5;
    localparam int NB_BLK     = 4;

    logic                  CLK100MHZ;
    logic                  rst;
    logic                  i_start;
    logic                  i_next;
    logic [NB_ADDRESS-1:0] i_last_addr;
    logic [NB_BLK-1:0]     i_nblk;
    logic [NB_ADDRESS-1:0] o_RAddr;
    logic [NB_ADDRESS-1:0] o_WAddr;
    logic                  o_sop;
    logic                  o_eop;
    logic                  o_chblk;
    logic                  o_valid;
    logic [NB_BLK-1:0]     o_blk_idx;
    logic                  o_busy;

    int n_vec = 0;
    int n_err = 0;
    int n_chblk_pulses = 0;

    logic [31:0] exp_q[$];

    conv_seq_fsm #(
        .NB_ADDRESS (NB_ADDRESS),
        .LATENCY    (LATENCY),
        .NB_BLK     (NB_BLK)
    ) dut (
        .CLK100MHZ   (CLK100MHZ),
        .rst         (rst),
        .i_start     (i_start),
        .i_next      (i_next),
        .i_last_addr (i_last_addr),
        .i_nblk      (i_nblk),
        .o_RAddr     (o_RAddr),
        .o_WAddr     (o_WAddr),
        .o_sop       (o_sop),
        .o_eop       (o_eop),
        .o_chblk     (o_chblk),
        .o_valid     (o_valid),
        .o_blk_idx   (o_blk_idx),
        .o_busy      (o_busy)
    );

    initial CLK100MHZ = 1'b0;
    always #5 CLK100MHZ = ~CLK100MHZ;

    // Vector layout: {pad3, sop, eop, chblk, valid, busy, blk[3:0], waddr[9:0], raddr[9:0]}
    function automatic logic [31:0] idle_v(input int ra, input int blk);
        return {3'b000, 5'b01000, 4'(blk), 10'd0, 10'(ra)};
    endfunction

    function automatic logic [31:0] run_v(input int ra, input int wa, input int blk);
        return {3'b000, 5'b10011, 4'(blk), 10'(wa), 10'(ra)};
    endfunction

    function automatic logic [31:0] chblk_v(input int blk);
        return {3'b000, 5'b00101, 4'(blk), 10'd0, 10'd0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Queue the expectation, clock once, then compare what the DUT registered.
    task automatic cyc(input logic [31:0] e, input string tag);
        logic [31:0] got;
        logic [31:0] want;
        exp_q.push_back(e);
        @(posedge CLK100MHZ);
        #1;
        got  = {3'b000, o_sop, o_eop, o_chblk, o_valid, o_busy, o_blk_idx, o_WAddr, o_RAddr};
        if (o_chblk === 1'b1) n_chblk_pulses++;
        want = exp_q.pop_front();
        check(tag, got, want);
    endtask

    // Whole frame from a start edge; inputs are scrambled after start to show they are latched.
    task automatic frame(input int last, input int nblk, input int glitch_c, input bit with_next,
                         input string tag);
        i_last_addr = 10'(last);
        i_nblk      = 4'(nblk);
        i_start     = 1'b1;
        i_next      = with_next;
        for (int b = 0; b <= nblk; b++) begin
            for (int c = 0; c <= last + LATENCY; c++) begin
                cyc(run_v((c < last) ? c : last, (c >= LATENCY) ? c - LATENCY : 0, b), tag);
                i_start     = (b == 0 && c == glitch_c);
                i_next      = (c == 2);
                i_last_addr = 10'($urandom);
                i_nblk      = 4'($urandom);
            end
            if (b < nblk) cyc(chblk_v(b), {tag, "_chblk"});
        end
        cyc(idle_v(0, nblk), {tag, "_end"});
    endtask

    initial begin
        rst         = 1'b1;
        i_start     = 1'b0;
        i_next      = 1'b0;
        i_last_addr = '0;
        i_nblk      = '0;

        cyc(idle_v(0, 0), "reset");
        rst = 1'b0;
        cyc(idle_v(0, 0), "idle0");
        cyc(idle_v(0, 0), "idle1");

        frame(7, 0, -1, 1'b0, "frame7");
        cyc(idle_v(0, 0), "gap_a");
        frame(7, 0, 3, 1'b0, "restart_ignored");
        cyc(idle_v(0, 0), "gap_b");

        n_chblk_pulses = 0;
        frame(7, 1, -1, 1'b0, "two_blk");
        check("chblk_count", 32'(n_chblk_pulses), 32'd1);
        cyc(idle_v(0, 1), "gap_c");

        frame(0, 0, -1, 1'b0, "last0");
        cyc(idle_v(0, 0), "gap_d");

        frame(2, 0, -1, 1'b0, "last2");
        begin
            int exp_ra[4] = '{1, 2, 0, 1};
            for (int k = 0; k < 4; k++) begin
                i_next = 1'b1;
                cyc(idle_v(exp_ra[k], 0), "next_step");
                i_next = 1'b0;
                cyc(idle_v(exp_ra[k], 0), "next_hold");
            end
        end

        frame(7, 0, -1, 1'b1, "start_and_next");
        cyc(idle_v(0, 0), "gap_e");

        // Reset in the middle of a run while start is held high.
        i_last_addr = 10'd7;
        i_nblk      = 4'd0;
        i_start     = 1'b1;
        for (int c = 0; c <= 4; c++) cyc(run_v(c, 0, 0), "pre_rst_run");
        rst = 1'b1;
        cyc(idle_v(0, 0), "rst_midrun");
        rst = 1'b0;
        for (int k = 0; k < 3; k++) cyc(idle_v(0, 0), "start_held");
        i_start = 1'b0;
        cyc(idle_v(0, 0), "start_low");
        i_next = 1'b1;
        cyc(idle_v(0, 0), "wrap_last0");
        i_next = 1'b0;
        cyc(idle_v(0, 0), "wrap_hold");
        frame(7, 0, -1, 1'b0, "after_rst");

        // Reset wins over a fresh start edge in the same cycle.
        i_start = 1'b1;
        rst     = 1'b1;
        cyc(idle_v(0, 0), "rst_vs_start");
        rst = 1'b0;
        cyc(idle_v(0, 0), "no_edge_after_rst");
        i_start = 1'b0;
        cyc(idle_v(0, 0), "final_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
